// File: rtl/shift_add_mult_n.sv
// shift_add_mult_n: sequential signed (two's complement) WIDTH x WIDTH multiplier.
// The product is built in {A,B} by a shift-add loop whose last partial product
// is subtracted, because the multiplier MSB carries negative weight. A holds the
// high half, B the low half, and X is the sign-extension bit of A.
// Optional feature macro: FAST_EN. When defined, each ADD+SHIFT pair is merged
// into a single CALC state, giving one cycle per bit with identical results.
module shift_add_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] Sin,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, ADD, SHIFT, CALC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg;
  logic             x_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   a_ext, s_ext, sum, step;

  assign Aval = a_reg;
  assign Bval = b_reg;
  assign X    = x_reg;

  // Conditional add/subtract of the multiplicand into sign-extended A; the
  // final iteration subtracts because the multiplier MSB has negative weight.
  always_comb begin
    a_ext = {a_reg[WIDTH-1], a_reg};
    s_ext = {s_reg[WIDTH-1], s_reg};
    sum   = (cnt == LAST) ? (a_ext - s_ext) : (a_ext + s_ext);
    step  = b_reg[0] ? sum : {x_reg, a_reg};
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; Run is level-sensitive, so DONE waits for Run to drop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (Run) begin
`ifdef FAST_EN
          state_next = CALC;
`else
          state_next = ADD;
`endif
        end
      end
      ADD:   state_next = SHIFT;
      SHIFT: state_next = (cnt == LAST) ? DONE : ADD;
      CALC:  state_next = (cnt == LAST) ? DONE : CALC;
      DONE:  if (!Run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded only from the state register.
  always_comb begin
    Busy = (state == ADD) || (state == SHIFT) || (state == CALC);
    Done = (state == DONE);
  end

  // Datapath: operand capture in IDLE, then add and arithmetic shift of {X,A,B}.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
      s_reg <= '0;
      x_reg <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Run) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            cnt   <= '0;
            s_reg <= Sin;
          end else if (ClearA_LoadB) begin
            a_reg <= '0;
            x_reg <= 1'b0;
            b_reg <= Sin;
          end
        end
        ADD: begin
          a_reg <= step[WIDTH-1:0];
          x_reg <= step[WIDTH];
        end
        SHIFT: begin
          a_reg <= {x_reg, a_reg[WIDTH-1:1]};
          b_reg <= {a_reg[0], b_reg[WIDTH-1:1]};
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        CALC: begin
          a_reg <= {step[WIDTH], step[WIDTH-1:1]};
          b_reg <= {step[0], b_reg[WIDTH-1:1]};
          x_reg <= step[WIDTH];
          if (cnt != LAST) cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
